// File: rtl/br_redirect_ctrl.sv
// Redirect sequencer for the PC-relative branch unit: forwards writebacks, flushes and
// redirects fetch on taken branches, then drains wrong-path results. Optional: BR_MISALIGN_CHECK_EN.
module br_redirect_ctrl #(
   parameter int ADDR_W       = 32,
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic [4:0]        res_rd_idx,
   input  logic [ADDR_W-1:0] res_rd_val,
   input  logic              res_br_valid,
   input  logic [ADDR_W-1:0] res_br_target,
   output logic              wb_valid,
   output logic [4:0]        wb_rd_idx,
   output logic [ADDR_W-1:0] wb_rd_val,
   output logic              flush,
   output logic              redirect_valid,
   input  logic              redirect_ready,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              ex_valid,
   output logic [ADDR_W-1:0] ex_tval,
   output logic [CNT_W-1:0]  br_taken_cnt,
   output logic [CNT_W-1:0]  squash_cnt
);

   // state    | meaning
   // IDLE     | forwarding results; a taken branch starts a redirect
   // REDIRECT | redirect_valid held until fetch accepts; results dropped
   // DRAIN    | fixed window of dropped wrong-path results
   typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_DRAIN} state_t;

   localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   state_t            state, state_nxt;
   logic [DW-1:0]     drain_cnt, drain_nxt;
   logic              wb_valid_nxt;
   logic [4:0]        wb_idx_nxt;
   logic [ADDR_W-1:0] wb_val_nxt;
   logic              flush_nxt;
   logic              rv_nxt;
   logic [ADDR_W-1:0] pc_nxt;
   logic              ex_valid_nxt;
   logic [ADDR_W-1:0] ex_tval_nxt;
   logic [CNT_W-1:0]  taken_nxt;
   logic [CNT_W-1:0]  squash_nxt;
   logic              misalign;

   assign res_ready = 1'b1;

`ifdef BR_MISALIGN_CHECK_EN
   assign misalign = (res_br_target[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_nxt    = state;
      drain_nxt    = drain_cnt;
      wb_valid_nxt = 1'b0;
      wb_idx_nxt   = wb_rd_idx;
      wb_val_nxt   = wb_rd_val;
      flush_nxt    = 1'b0;
      rv_nxt       = redirect_valid;
      pc_nxt       = redirect_pc;
      ex_valid_nxt = 1'b0;
      ex_tval_nxt  = '0;
      taken_nxt    = br_taken_cnt;
      squash_nxt   = squash_cnt;
      case (state)
         S_IDLE: begin
            if (res_valid) begin
               // flush can only be high in IDLE after a misalign exception with no
               // drain window; the result behind it is wrong-path, and dropping it
               // keeps flush from firing on consecutive cycles.
               if (flush) begin
                  squash_nxt = squash_cnt + CNT_W'(1);
               end else if (res_br_valid && misalign) begin
                  ex_valid_nxt = 1'b1;
                  ex_tval_nxt  = res_br_target;
                  flush_nxt    = 1'b1;
                  squash_nxt   = squash_cnt + CNT_W'(1);
                  if (DRAIN_CYCLES > 0) begin
                     state_nxt = S_DRAIN;
                     drain_nxt = DW'(DRAIN_CYCLES);
                  end
               end else begin
                  wb_valid_nxt = 1'b1;
                  wb_idx_nxt   = res_rd_idx;
                  wb_val_nxt   = res_rd_val;
                  if (res_br_valid) begin
                     pc_nxt    = res_br_target;
                     flush_nxt = 1'b1;
                     rv_nxt    = 1'b1;
                     taken_nxt = br_taken_cnt + CNT_W'(1);
                     state_nxt = S_REDIRECT;
                  end
               end
            end
         end
         S_REDIRECT: begin
            if (res_valid) squash_nxt = squash_cnt + CNT_W'(1);
            if (redirect_ready) begin
               rv_nxt = 1'b0;
               if (DRAIN_CYCLES > 0) begin
                  state_nxt = S_DRAIN;
                  drain_nxt = DW'(DRAIN_CYCLES);
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         S_DRAIN: begin
            if (res_valid) squash_nxt = squash_cnt + CNT_W'(1);
            if (drain_cnt <= DW'(1)) begin
               drain_nxt = '0;
               state_nxt = S_IDLE;
            end else begin
               drain_nxt = drain_cnt - DW'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            drain_nxt = '0;
            rv_nxt    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         drain_cnt      <= '0;
         wb_valid       <= 1'b0;
         wb_rd_idx      <= '0;
         wb_rd_val      <= '0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         ex_valid       <= 1'b0;
         ex_tval        <= '0;
         br_taken_cnt   <= '0;
         squash_cnt     <= '0;
      end else begin
         state          <= state_nxt;
         drain_cnt      <= drain_nxt;
         wb_valid       <= wb_valid_nxt;
         wb_rd_idx      <= wb_idx_nxt;
         wb_rd_val      <= wb_val_nxt;
         flush          <= flush_nxt;
         redirect_valid <= rv_nxt;
         redirect_pc    <= pc_nxt;
         ex_valid       <= ex_valid_nxt;
         ex_tval        <= ex_tval_nxt;
         br_taken_cnt   <= taken_nxt;
         squash_cnt     <= squash_nxt;
      end
   end

endmodule

// File: doc/br_redirect_ctrl.md
Name: br_redirect_ctrl

Overview:
- Sequences front-end redirects for the PC-relative branch unit (JAL, conditional branches, AUIPC).
- Consumes that unit's execution results, forwards non-squashed writebacks, and on every taken branch: pulses a pipeline flush, holds a redirect request to fetch until it is accepted, then drops wrong-path results for a fixed drain window.
- The front end predicts not-taken (PC+4), so every br_valid=1 result is a redirect.

Parameters:
- ADDR_W, 32, width of PC, branch target and register value.
- DRAIN_CYCLES, 2, cycles after redirect acceptance during which incoming results are dropped; 0 allowed.
- CNT_W, 32, width of taken-branch and squash counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- res_valid  in  1  execution result valid
- res_ready  out  1  result accepted
- res_rd_idx  in  5  destination register
- res_rd_val  in  ADDR_W  destination value
- res_br_valid  in  1  branch taken
- res_br_target  in  ADDR_W  branch target
- wb_valid  out  1  registered writeback valid
- wb_rd_idx  out  5  registered writeback register
- wb_rd_val  out  ADDR_W  registered writeback value
- flush  out  1  one-cycle pipeline flush pulse
- redirect_valid  out  1  redirect request to fetch
- redirect_ready  in  1  fetch accepts redirect
- redirect_pc  out  ADDR_W  redirect target
- ex_valid  out  1  exception pulse (optional feature only; else tied 0)
- ex_tval  out  ADDR_W  faulting target (optional feature only; else tied 0)
- br_taken_cnt  out  CNT_W  redirects issued
- squash_cnt  out  CNT_W  results dropped

Behaviour:
- Reset values: state IDLE; all outputs 0; counters 0; drain counter 0. rst takes priority over every other event and aborts a pending redirect or drain.
- res_ready = 1 in every state. Results are never back-pressured; they are either forwarded or dropped.
- IDLE:
  - An accepted result (res_valid=1) registers wb_valid/wb_rd_idx/wb_rd_val on the next edge (latency 1). wb_valid is 0 on cycles with no accepted result.
  - If res_br_valid=1, the same edge also: latches res_br_target into redirect_pc, sets flush=1 for exactly one cycle, sets redirect_valid=1, increments br_taken_cnt, and moves to REDIRECT.
  - The branch's own writeback (JAL link) is still forwarded.
- REDIRECT:
  - redirect_valid held at 1; redirect_pc stable.
  - Every accepted result is dropped (wb_valid=0) and increments squash_cnt, including any res_br_valid=1 result (no nested redirect).
  - On redirect_ready=1: redirect_valid goes 0 on the next edge. If DRAIN_CYCLES>0, go to DRAIN with the drain counter loaded to DRAIN_CYCLES; else go to IDLE.
  - redirect_ready in the first cycle redirect_valid is high gives a handshake of exactly one cycle.
- DRAIN:
  - Results are dropped and counted as in REDIRECT.
  - The drain counter decrements each cycle; when it reaches 1, the next state is IDLE. DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
- redirect_ready is ignored outside REDIRECT.
- Counters wrap modulo 2^CNT_W.
- flush is never high on two consecutive cycles.

Optional Feature:
- Macro: BR_MISALIGN_CHECK_EN.
- When defined, in IDLE a taken result with res_br_target[1:0]!=0 does not redirect:
  - ex_valid pulses 1 for one cycle with ex_tval=target, and flush pulses.
  - The writeback is suppressed and the result is counted in squash_cnt; br_taken_cnt is not incremented.
  - The block goes to DRAIN (IDLE if DRAIN_CYCLES=0).
- When undefined: ex_valid and ex_tval are tied 0, and every taken target is redirected unchanged.

Test Plan:
- Reset, then non-branch result rd=5, val=0x1234 -> one cycle later wb_valid=1, wb_rd_idx=5, wb_rd_val=0x1234; flush=0, redirect_valid=0.
- Taken JAL rd=1, val=0x104, target=0x200, redirect_ready held 1 -> next cycle flush=1, redirect_valid=1, redirect_pc=0x200, wb_rd_val=0x104; following cycle redirect_valid=0; with DRAIN_CYCLES=2, the two results after that are dropped; br_taken_cnt=1.
- Taken branch target=0x80, redirect_ready low 3 cycles, results each cycle -> redirect_valid held 4 cycles, pc stable at 0x80, squash_cnt=4+DRAIN_CYCLES, no wb_valid.
- Second taken branch (target 0x300) arriving during REDIRECT -> dropped, redirect_pc stays 0x80, br_taken_cnt unchanged.
- rst asserted mid-REDIRECT -> next cycle all outputs 0, counters 0; result after reset forwarded normally.
- With BR_MISALIGN_CHECK_EN, taken target=0x202 -> ex_valid=1, ex_tval=0x202, flush=1, redirect_valid stays 0, br_taken_cnt=0, squash_cnt=1.
